cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the common data bus (CDB) broadcast slots among the functional units (ALU, MUL, ...) of the out-of-order core.
- Each FU hands a completed result to the block over a valid/ready handshake. The block holds it in a one-entry per-FU holding register.
- Each cycle it grants up to N_BUS held results by round-robin and drives them onto registered CDB outputs, which the ROB, reservation stations and physical register file consume.
- A flush input (branch mispredict) discards all in-flight results.

Parameters:
- N_REQ, 2, number of requesting FUs (equals N_ALU + N_MUL).
- N_BUS, 1, number of CDB broadcast slots per cycle; legal range 1..N_REQ.
- ROB_IDX_W, 3, ROB id width, $clog2(ROB_D).
- PREG_W, 6, physical register index width, $clog2(TABLE_ENTRIES).

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of all held and outgoing results.
- req_valid  in  [N_REQ]  FU i offers a result.
- req_ready  out  [N_REQ]  block accepts FU i's result this cycle.
- req_data  in  cdb_entry_t [N_REQ]  result payload per FU.
- cdb_valid  out  [N_BUS]  slot j carries a valid broadcast.
- cdb_data  out  cdb_entry_t [N_BUS]  broadcast payload per slot.
- cdb_src  out  [N_BUS][$clog2(N_REQ)]  index of the FU that produced slot j (debug/perf).

Behaviour:
- Reset: all hold_valid = 0; cdb_valid = 0; cdb_data = 0; cdb_src = 0; rr_ptr = 0. During reset, req_ready = 0.
- Holding register per FU: hold_valid[i], hold_data[i].
- Handshake: req_ready[i] = ~rst & ~flush & (~hold_valid[i] | grant[i]), where grant is combinational in the same cycle.
  - Transfer occurs when req_valid[i] & req_ready[i].
  - On transfer, hold_data[i] <= req_data[i] and hold_valid[i] <= 1.
  - Otherwise, if grant[i], then hold_valid[i] <= 0.
- Arbitration (combinational, per cycle):
  - Scan requesters starting at rr_ptr, wrapping modulo N_REQ.
  - Grant the first N_BUS with hold_valid = 1.
  - Slot order follows scan order: the first winner goes to slot 0.
  - Only held entries compete. A request arriving this cycle cannot win this cycle (no bypass).
- Output register, loaded on each clock edge:
  - cdb_valid[j] <= slot j granted.
  - cdb_data[j] <= winner's hold_data.
  - cdb_src[j] <= winner index.
  - Ungranted slots drive cdb_valid = 0; data is don't-care but holds its previous value.
- Latency: a result accepted in cycle t is held in t+1. If granted in t+1, it appears with cdb_valid = 1 in t+2. The minimum is 2 cycles.
- Throughput: N_BUS results per cycle. An FU may transfer a new result in the same cycle its held one is granted, sustaining 1 per cycle per FU when uncontended.
- Round-robin update: if any grant occurred, rr_ptr <= (index of last winner + 1) mod N_REQ. Otherwise rr_ptr is unchanged.
- Fairness: a held entry is granted within ceil(N_REQ/N_BUS) cycles of becoming held.
- Flush (priority over everything except rst):
  - Next cycle: all hold_valid = 0 and all cdb_valid = 0.
  - No transfers in the flush cycle, since req_ready = 0.
  - rr_ptr is unchanged.
  - Results already on the CDB in the flush cycle still broadcast this cycle; the consumer handles squashing.
- Simultaneous transfer and grant on the same FU: the new data wins; hold_valid stays 1.
- Reset mid-operation: all state is cleared on the next edge and held results are lost, matching a full-pipeline reset.
- All FUs idle: cdb_valid = 0; no state change.

Decomposition:
- Package rv32i_types gains:
  - cdb_entry_t, packed: rob_id[ROB_IDX_W], preg[PREG_W], value[31:0], br_taken, mispredict (43 bits at defaults).
  - Localparam N_BUS = 1.
  - cdb_t becomes cdb_entry_t [N_BUS].
- One sub-module is natural: rr_select, a parameterised rotate–priority-encode–unrotate that returns up to N_BUS one-hot grants and the last-winner index. It is reusable for reservation station issue selection.

Test Plan:
- Reset: hold rst for 2 cycles with req_valid = 2'b11 → req_ready = 0 and cdb_valid = 0 throughout; after release, the first transfer is seen 1 cycle later.
- Single FU: ALU (i=0) offers rob_id 3, preg 17, value 0xDEADBEEF in cycle 0 → cdb_valid = 1, cdb_data matches, cdb_src = 0 in cycle 2; the output stays quiet afterwards.
- Contention, N_BUS = 1: both FUs offer every cycle for 8 cycles → cdb_src alternates 0,1,0,1…; each FU sees req_ready = 1 on alternate cycles; no result is lost or duplicated (scoreboard on rob_id).
- Back-to-back: only MUL offers values 1..5 on consecutive cycles → the CDB shows 1..5 on consecutive cycles starting 2 cycles later; req_ready stays 1.
- Flush: both FUs hold results and cdb_valid = 1 when flush pulses for 1 cycle → next cycle cdb_valid = 0, hold_valid = 0, req_ready = 0 during the pulse; new results after the flush broadcast normally.
- N_BUS = 2, N_REQ = 3: all three offer simultaneously → cycle 2 shows slots {0, 1}, cycle 3 shows slot 0 = FU 2; rr_ptr = 0 afterwards.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB payload types for the result-broadcast arbiter and its consumers.
package cdb_arbiter_pkg;

  localparam int ROB_IDX_W = 3;
  localparam int PREG_W    = 6;
  localparam int CDB_N_BUS = 1;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_id;
    logic [PREG_W-1:0]    preg;
    logic [31:0]          value;
    logic                 br_taken;
    logic                 mispredict;
  } cdb_entry_t;

  typedef cdb_entry_t [CDB_N_BUS-1:0] cdb_t;

endpackage

// File: rtl/cdb_arbiter_rr_select.sv
// Round-robin selector: scans requesters from ptr_i (wrapping) and grants up to
// N_BUS of them, in scan order, one per output slot.
module cdb_arbiter_rr_select #(
  parameter int N_REQ = 2,
  parameter int N_BUS = 1,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0]            req_i,
  input  logic [IDX_W-1:0]            ptr_i,
  output logic [N_REQ-1:0]            grant_o,
  output logic [N_BUS-1:0]            slot_vld_o,
  output logic [N_BUS-1:0][IDX_W-1:0] slot_idx_o,
  output logic                        any_o,
  output logic [IDX_W-1:0]            last_o
);

  always_comb begin
    int cnt;
    int idx;
    grant_o    = '0;
    slot_vld_o = '0;
    slot_idx_o = '0;
    last_o     = '0;
    cnt        = 0;
    idx        = 0;
    for (int d = 0; d < N_REQ; d++) begin
      idx = int'(ptr_i) + d;
      if (idx >= N_REQ) idx = idx - N_REQ;
      for (int i = 0; i < N_REQ; i++) begin
        if (i == idx && req_i[i] && cnt < N_BUS) begin
          grant_o[i] = 1'b1;
          // constant slot index keeps the slot write a plain mux
          for (int j = 0; j < N_BUS; j++) begin
            if (j == cnt) begin
              slot_vld_o[j] = 1'b1;
              slot_idx_o[j] = IDX_W'(i);
            end
          end
          last_o = IDX_W'(i);
          cnt    = cnt + 1;
        end
      end
    end
  end

  assign any_o = |grant_o;

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding register per FU, round-robin grant of up to N_BUS
// held results per cycle onto registered broadcast slots.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int N_BUS = cdb_arbiter_pkg::CDB_N_BUS,
  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic [N_REQ-1:0]            req_valid_i,
  output logic [N_REQ-1:0]            req_ready_o,
  input  cdb_entry_t [N_REQ-1:0]      req_data_i,
  output logic [N_BUS-1:0]            cdb_valid_o,
  output cdb_entry_t [N_BUS-1:0]      cdb_data_o,
  output logic [N_BUS-1:0][SRC_W-1:0] cdb_src_o
);

  logic [N_REQ-1:0]            hold_valid_q, hold_valid_d;
  cdb_entry_t [N_REQ-1:0]      hold_data_q, hold_data_d;
  logic [SRC_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [N_BUS-1:0]            cdb_valid_q, cdb_valid_d;
  cdb_entry_t [N_BUS-1:0]      cdb_data_q, cdb_data_d;
  logic [N_BUS-1:0][SRC_W-1:0] cdb_src_q, cdb_src_d;

  logic [N_REQ-1:0]            grant;
  logic [N_BUS-1:0]            slot_vld;
  logic [N_BUS-1:0][SRC_W-1:0] slot_idx;
  logic                        any_grant;
  logic [SRC_W-1:0]            last_win;
  logic [N_REQ-1:0]            xfer;

  cdb_arbiter_rr_select #(
    .N_REQ (N_REQ),
    .N_BUS (N_BUS)
  ) u_rr_select (
    .req_i      (hold_valid_q),
    .ptr_i      (rr_ptr_q),
    .grant_o    (grant),
    .slot_vld_o (slot_vld),
    .slot_idx_o (slot_idx),
    .any_o      (any_grant),
    .last_o     (last_win)
  );

  // A granted entry frees its slot in the same cycle, so an FU can stream.
  assign req_ready_o = (rst_i || flush_i) ? '0 : (~hold_valid_q | grant);
  assign xfer        = req_valid_i & req_ready_o;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (xfer[i]) begin
        hold_valid_d[i] = 1'b1;
        hold_data_d[i]  = req_data_i[i];
      end else if (grant[i]) begin
        hold_valid_d[i] = 1'b0;
      end
    end

    rr_ptr_d = rr_ptr_q;
    if (any_grant) rr_ptr_d = (int'(last_win) == N_REQ - 1) ? '0 : last_win + 1'b1;

    cdb_valid_d = slot_vld;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    for (int j = 0; j < N_BUS; j++) begin
      if (slot_vld[j]) begin
        cdb_data_d[j] = hold_data_q[slot_idx[j]];
        cdb_src_d[j]  = slot_idx[j];
      end
    end

    // Squash everything in flight; the pointer keeps its place for fairness.
    if (flush_i) begin
      hold_valid_d = '0;
      cdb_valid_d  = '0;
      rr_ptr_d     = rr_ptr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_valid_q <= '0;
      hold_data_q  <= '0;
      rr_ptr_q     <= '0;
      cdb_valid_q  <= '0;
      cdb_data_q   <= '0;
      cdb_src_q    <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      rr_ptr_q     <= rr_ptr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_data_q   <= cdb_data_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

  assign cdb_valid_o = cdb_valid_q;
  assign cdb_data_o  = cdb_data_q;
  assign cdb_src_o   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: 2-FU/1-slot instance with per-FU scoreboards, plus a
// 3-FU/2-slot instance for multi-slot ordering and pointer wrap.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;
  int pushed0 = 0;
  int pushed1 = 0;

  logic              rst = 1'b1, flush = 1'b0;
  logic [1:0]        rv = '0, rr;
  cdb_entry_t [1:0]  rd = '0;
  logic [0:0]        cv;
  cdb_entry_t [0:0]  cd;
  logic [0:0][0:0]   cs;

  cdb_arbiter #(.N_REQ(2), .N_BUS(1)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(rv), .req_ready_o(rr), .req_data_i(rd),
    .cdb_valid_o(cv), .cdb_data_o(cd), .cdb_src_o(cs)
  );

  logic              rst1 = 1'b1, flush1 = 1'b0;
  logic [2:0]        rv1 = '0, rr1;
  cdb_entry_t [2:0]  rd1 = '0;
  logic [1:0]        cv1;
  cdb_entry_t [1:0]  cd1;
  logic [1:0][1:0]   cs1;

  cdb_arbiter #(.N_REQ(3), .N_BUS(2)) u_dut1 (
    .clk_i(clk), .rst_i(rst1), .flush_i(flush1),
    .req_valid_i(rv1), .req_ready_o(rr1), .req_data_i(rd1),
    .cdb_valid_o(cv1), .cdb_data_o(cd1), .cdb_src_o(cs1)
  );

  cdb_entry_t sb0[$];
  cdb_entry_t sb1[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic cdb_entry_t mk(input int rob, input int preg, input logic [31:0] val);
    cdb_entry_t e;
    e.rob_id     = rob[ROB_IDX_W-1:0];
    e.preg       = preg[PREG_W-1:0];
    e.value      = val;
    e.br_taken   = rob[0];
    e.mispredict = preg[0];
    return e;
  endfunction

  // One cycle on dut0: drive, check ready/CDB against expectations, score
  // broadcasts against what each FU handed over, then advance to next negedge.
  task automatic cyc(input logic r, input logic f, input logic [1:0] v,
                     input cdb_entry_t d0, input cdb_entry_t d1,
                     input logic [1:0] e_rdy, input logic e_cv, input logic e_src);
    cdb_entry_t e;
    rst = r; flush = f; rv = v; rd[0] = d0; rd[1] = d1;
    #1;
    chk("req_ready", rr, e_rdy);
    chk("cdb_valid", cv, e_cv);
    if (cv[0]) begin
      if (e_cv) chk("cdb_src", cs[0], e_src);
      if ((cs[0] == 1'b0 && sb0.size() == 0) || (cs[0] == 1'b1 && sb1.size() == 0))
        chk("cdb_extra", cv, 1'b0);
      else begin
        e = cs[0] ? sb1.pop_front() : sb0.pop_front();
        chk("cdb_data", cd[0], e);
      end
    end
    if (v[0] && rr[0]) begin sb0.push_back(d0); pushed0++; end
    if (v[1] && rr[1]) begin sb1.push_back(d1); pushed1++; end
    @(negedge clk);
  endtask

  task automatic do_reset();
    cdb_entry_t z;
    z = '0;
    for (int c = 0; c < 2; c++) cyc(1'b1, 1'b0, 2'b11, z, z, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic sb_empty(input string tag);
    chk({tag, "_sb0_left"}, sb0.size(), 0);
    chk({tag, "_sb1_left"}, sb1.size(), 0);
  endtask

  initial begin
    cdb_entry_t z;
    cdb_entry_t e1[3];
    logic [1:0] er;
    z = '0;
    @(negedge clk);

    // reset held with both FUs offering, then first transfer after release
    do_reset();
    cyc(1'b0, 1'b0, 2'b11, mk(1, 1, 32'h11), mk(2, 2, 32'h22), 2'b11, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'b00, z, z, 2'b01, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'b00, z, z, 2'b11, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 2'b00, z, z, 2'b11, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 2'b00, z, z, 2'b11, 1'b0, 1'b0);
    sb_empty("rst");

    // single ALU result, two-cycle latency
    do_reset();
    cyc(1'b0, 1'b0, 2'b01, mk(3, 17, 32'hDEADBEEF), z, 2'b11, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'b00, z, z, 2'b11, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'b00, z, z, 2'b11, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 2'b00, z, z, 2'b11, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'b00, z, z, 2'b11, 1'b0, 1'b0);
    sb_empty("single");

    // contention: both FUs offer for 8 cycles, grants alternate
    do_reset();
    pushed0 = 0; pushed1 = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 0)      er = 2'b11;
      else if (c < 8)  er = (c % 2 == 1) ? 2'b01 : 2'b10;
      else if (c == 8) er = 2'b10;
      else             er = 2'b11;
      cyc(1'b0, 1'b0, (c < 8) ? 2'b11 : 2'b00,
          mk(pushed0, pushed0, $urandom), mk(pushed1, 32 + pushed1, $urandom),
          er, (c >= 2 && c <= 10), (c % 2 == 1));
    end
    chk("cont_pushed0", pushed0, 5);
    chk("cont_pushed1", pushed1, 4);
    sb_empty("cont");

    // back-to-back MUL results 1..5
    do_reset();
    for (int c = 0; c < 8; c++)
      cyc(1'b0, 1'b0, (c < 5) ? 2'b10 : 2'b00, z, mk(c, 40 + c, c + 1),
          2'b11, (c >= 2 && c <= 6), 1'b1);
    sb_empty("b2b");

    // flush with both FUs holding and a broadcast on the bus
    do_reset();
    cyc(1'b0, 1'b0, 2'b11, mk(1, 5, 32'h100), mk(2, 6, 32'h200), 2'b11, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'b01, mk(3, 7, 32'h101), z, 2'b01, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 2'b11, mk(4, 8, 32'h102), mk(5, 9, 32'h201), 2'b00, 1'b1, 1'b0);
    sb0.delete();
    sb1.delete();
    cyc(1'b0, 1'b0, 2'b10, z, mk(6, 10, 32'h300), 2'b11, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'b00, z, z, 2'b11, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'b00, z, z, 2'b11, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 2'b00, z, z, 2'b11, 1'b0, 1'b0);
    sb_empty("flush");

    // N_REQ=3, N_BUS=2: all offer at once
    rst1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e1[i] = mk(i + 1, 20 + i, $urandom);
      rd1[i] = e1[i];
    end
    rv1 = 3'b111;
    #1;
    chk("b2_rdy_c0", rr1, 3'b111);
    chk("b2_cv_c0", cv1, 2'b00);
    @(negedge clk);
    rv1 = 3'b000;
    #1;
    chk("b2_rdy_c1", rr1, 3'b011);
    chk("b2_cv_c1", cv1, 2'b00);
    @(negedge clk);
    #1;
    chk("b2_rdy_c2", rr1, 3'b111);
    chk("b2_cv_c2", cv1, 2'b11);
    chk("b2_src0_c2", cs1[0], 2'd0);
    chk("b2_src1_c2", cs1[1], 2'd1);
    chk("b2_data0_c2", cd1[0], e1[0]);
    chk("b2_data1_c2", cd1[1], e1[1]);
    @(negedge clk);
    #1;
    chk("b2_cv_c3", cv1, 2'b01);
    chk("b2_src0_c3", cs1[0], 2'd2);
    chk("b2_data0_c3", cd1[0], e1[2]);
    @(negedge clk);
    #1;
    chk("b2_cv_c4", cv1, 2'b00);
    // pointer must be back at 0: a fresh round wins slots {0,1} again
    rv1 = 3'b111;
    @(negedge clk);
    rv1 = 3'b000;
    @(negedge clk);
    #1;
    chk("b2_cv_c6", cv1, 2'b11);
    chk("b2_src0_c6", cs1[0], 2'd0);
    chk("b2_src1_c6", cs1[1], 2'd1);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
